// File: rtl/bcd_serial_adder_ctrl.sv
// Serial packed-BCD adder: latches two DIGITS-wide operands on start and adds
// one decimal digit per clock, least-significant digit first.
module bcd_serial_adder_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                err
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Handshake: start is a level request, accepted on any edge where the
    // FSM is IDLE or DONE; done pulses for one cycle when sum/cout/err are valid.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [W-1:0]  a_d;
    logic [W-1:0]  b_d;
    logic          carry;
    logic [IW-1:0] idx;

    logic [3:0] a_dig;
    logic [3:0] b_dig;
    logic [4:0] raw;
    logic       dig_carry;
    logic [3:0] dig_val;
    logic       dig_bad;
    logic       last_dig;

    // Single-digit BCD add; the +6 correction only needs the low nibble.
    always_comb begin
        a_dig     = a_d[4*idx +: 4];
        b_dig     = b_d[4*idx +: 4];
        raw       = 5'(a_dig) + 5'(b_dig) + 5'(carry);
        dig_carry = (raw > 5'd9);
        dig_val   = dig_carry ? (raw[3:0] + 4'd6) : raw[3:0];
        dig_bad   = (a_dig > 4'd9) || (b_dig > 4'd9);
        last_dig  = (idx == IW'(DIGITS - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_d   <= '0;
            b_d   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= ADD;
                        a_d   <= a;
                        b_d   <= b;
                        carry <= cin;
                        idx   <= '0;
                        busy  <= 1'b1;
                        sum   <= '0;
                        cout  <= 1'b0;
                        err   <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                ADD: begin
                    sum[4*idx +: 4] <= dig_val;
                    carry           <= dig_carry;
                    err             <= err | dig_bad;
                    if (last_dig) begin
                        state <= DONE;
                        idx   <= '0;
                        cout  <= dig_carry;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Directed bench for bcd_serial_adder_ctrl (DIGITS=4) with hand-computed sums.
module tb_bcd_serial_adder_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        err;

    int checks = 0;
    int errors = 0;

    bcd_serial_adder_ctrl #(.DIGITS(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waits (bounded) for done; returns edges elapsed and whether it came.
    task automatic wait_done(output int lat, output bit seen);
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_add(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                          output logic [15:0] s, output logic co, output logic e,
                          output int lat, output bit seen);
        a = av; b = bv; cin = cv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, seen);
        s = sum; co = cout; e = err;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL reset_sum got %h exp 0000", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b exp 0", cout); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    endtask

    task automatic test_basic;
        int busy_cnt;
        int lat;
        bit seen;
        a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_start got %b exp 1", busy); end
        busy_cnt = 1;
        lat = 0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
        end
        checks++; if (!seen || lat != 4) begin errors++; $display("FAIL basic_latency got %0d seen %b exp 4", lat, seen); end
        checks++; if (busy_cnt != 4) begin errors++; $display("FAIL basic_busy_cycles got %0d exp 4", busy_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b exp 0", busy); end
        checks++; if (sum !== 16'h6912) begin errors++; $display("FAIL basic_sum got %h exp 6912", sum); end
        checks++; if (cout !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL basic_flags got cout %b err %b exp 0 0", cout, err); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b exp 0", done); end
        checks++; if (sum !== 16'h6912) begin errors++; $display("FAIL basic_sum_hold got %h exp 6912", sum); end
    endtask

    task automatic test_ripple;
        logic [15:0] s; logic co; logic e; int lat; bit seen;
        do_add(16'h9999, 16'h0001, 1'b0, s, co, e, lat, seen);
        checks++; if (!seen || s !== 16'h0000 || co !== 1'b1 || e !== 1'b0) begin
            errors++; $display("FAIL ripple_9999 got %h cout %b err %b seen %b exp 0000 1 0", s, co, e, seen); end
        do_add(16'h0000, 16'h0000, 1'b1, s, co, e, lat, seen);
        checks++; if (!seen || s !== 16'h0001 || co !== 1'b0) begin
            errors++; $display("FAIL ripple_cin got %h cout %b exp 0001 0", s, co); end
    endtask

    task automatic test_correction;
        logic [15:0] s; logic co; logic e; int lat; bit seen;
        do_add(16'h0008, 16'h0009, 1'b1, s, co, e, lat, seen);
        checks++; if (!seen || s !== 16'h0018 || co !== 1'b0) begin
            errors++; $display("FAIL corr_8_9_1 got %h cout %b exp 0018 0", s, co); end
        do_add(16'h0004, 16'h0007, 1'b0, s, co, e, lat, seen);
        checks++; if (!seen || s !== 16'h0011 || co !== 1'b0) begin
            errors++; $display("FAIL corr_4_7 got %h cout %b exp 0011 0", s, co); end
        do_add(16'h9990, 16'h0010, 1'b0, s, co, e, lat, seen);
        checks++; if (!seen || s !== 16'h0000 || co !== 1'b1) begin
            errors++; $display("FAIL corr_9990_10 got %h cout %b exp 0000 1", s, co); end
    endtask

    task automatic test_err;
        logic [15:0] s; logic co; logic e; int lat; bit seen;
        do_add(16'h00A8, 16'h0000, 1'b0, s, co, e, lat, seen);
        checks++; if (!seen || e !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", e); end
        checks++; if (s !== 16'h0108 || co !== 1'b0) begin errors++; $display("FAIL err_sum got %h cout %b exp 0108 0", s, co); end
        do_add(16'h0001, 16'h0002, 1'b0, s, co, e, lat, seen);
        checks++; if (!seen || e !== 1'b0 || s !== 16'h0003) begin
            errors++; $display("FAIL err_clear got err %b sum %h exp 0 0003", e, s); end
    endtask

    task automatic test_ignore_start;
        int lat; bit seen;
        a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        a = 16'h4321; b = 16'h1111; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, seen);
        checks++; if (!seen || lat != 2) begin errors++; $display("FAIL ignore_latency got %0d seen %b exp 2", lat, seen); end
        checks++; if (sum !== 16'h6912 || cout !== 1'b0) begin
            errors++; $display("FAIL ignore_sum got %h cout %b exp 6912 0", sum, cout); end
    endtask

    task automatic test_back_to_back;
        int lat; bit seen;
        a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = 16'h4444; b = 16'h0505; cin = 1'b1;
        wait_done(lat, seen);
        checks++; if (!seen || sum !== 16'h3333 || cout !== 1'b0) begin
            errors++; $display("FAIL b2b_first got %h cout %b exp 3333 0", sum, cout); end
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1 || done !== 1'b0 || sum !== 16'h0000) begin
            errors++; $display("FAIL b2b_restart got busy %b done %b sum %h exp 1 0 0000", busy, done, sum); end
        wait_done(lat, seen);
        checks++; if (!seen || lat != 4) begin errors++; $display("FAIL b2b_latency got %0d seen %b exp 4", lat, seen); end
        checks++; if (sum !== 16'h4950 || cout !== 1'b0) begin
            errors++; $display("FAIL b2b_second got %h cout %b exp 4950 0", sum, cout); end
    endtask

    task automatic test_mid_reset;
        bit saw_done;
        a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL mrst_ctrl got busy %b done %b exp 0 0", busy, done); end
        checks++; if (sum !== 16'h0000 || cout !== 1'b0) begin
            errors++; $display("FAIL mrst_sum got %h cout %b exp 0000 0", sum, cout); end
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        checks++; if (saw_done) begin errors++; $display("FAIL mrst_no_done got activity 1 exp 0"); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ripple();
        test_correction();
        test_err();
        test_ignore_start();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
